// File: rtl/sdram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sdram_fifo_pkg
// Shared definitions for the host-to-SDRAM word FIFO path.
//   WORD_W         : FIFO / SDRAM write data width
//   BURST_LEN_DEF  : default number of words popped per burst
//   reader_state_e : state encoding of fifo_burst_reader
// Configuration macro: READER_TIMEOUT_EN adds the ST_ERROR state used by the
// reader's empty-FIFO timeout.
// -----------------------------------------------------------------------------
package sdram_fifo_pkg;

    localparam int WORD_W        = 32;
    localparam int BURST_LEN_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_DONE    = 3'd4
`ifdef READER_TIMEOUT_EN
        ,
        ST_ERROR   = 3'd5
`endif
    } reader_state_e;

endpackage : sdram_fifo_pkg

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
// Consumer side of the host-to-SDRAM word FIFO. On burst_start it pops
// BURST_LEN words, one at a time, and offers each to the SDRAM write datapath
// with an incrementing word address over a valid/ready handshake. The FIFO
// read port is registered: fifo_rdata is valid the cycle after the pop.
//
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   burst_start       : single-cycle request, honoured only when idle
//   start_addr        : first word address, sampled with burst_start
//   busy              : high while a burst is in progress
//   burst_done        : one-cycle pulse when a burst completes
//   fifo_empty        : FIFO empty flag
//   fifo_rdata        : FIFO read data (cycle after fifo_read_enable)
//   fifo_read_enable  : FIFO pop strobe (combinational, never when empty)
//   wr_valid/wr_ready : handshake towards the SDRAM write datapath
//   wr_addr, wr_data  : word address and data, stable while wr_valid && !wr_ready
//   wr_last           : final word of the burst, qualified by wr_valid
//   burst_error       : one-cycle timeout pulse
//
// Configuration macro: READER_TIMEOUT_EN
//   defined   : FETCH gives up after TIMEOUT_CYCLES consecutive empty cycles,
//               pulses burst_error and returns to idle without burst_done.
//   undefined : FETCH waits indefinitely, burst_error is tied low.
// -----------------------------------------------------------------------------
module fifo_burst_reader
    import sdram_fifo_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int ADDR_W    = 22
`ifdef READER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              burst_start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              burst_done,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_rdata,
    output logic              fifo_read_enable,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              wr_last,
    output logic              burst_error
);

    localparam int                 CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(BURST_LEN - 1);

    reader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

    // Output flops, loaded from the next-state decode so every output except
    // the pop strobe comes straight from a register.
    logic busy_q, busy_d;
    logic burst_done_q, burst_done_d;
    logic wr_valid_q, wr_valid_d;
    logic wr_last_q, wr_last_d;

`ifdef READER_TIMEOUT_EN
    localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            burst_error_q, burst_error_d;
`endif

    // Next-state, datapath and pop-strobe decode.
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        data_d           = data_q;
        word_cnt_d       = word_cnt_q;
        fifo_read_enable = 1'b0;
`ifdef READER_TIMEOUT_EN
        to_cnt_d         = to_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef READER_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                if (burst_start) begin
                    addr_d     = start_addr;
                    word_cnt_d = '0;
                    state_d    = ST_FETCH;
                end else begin
                    state_d    = ST_IDLE;
                end
            end

            ST_FETCH: begin
                if (!fifo_empty) begin
                    fifo_read_enable = 1'b1;
                    state_d          = ST_CAPTURE;
`ifdef READER_TIMEOUT_EN
                    to_cnt_d         = '0;
`endif
                end else begin
`ifdef READER_TIMEOUT_EN
                    // The cycle that would bring the count to TIMEOUT_CYCLES
                    // is the last tolerated one.
                    if (to_cnt_q == TO_LIMIT) begin
                        state_d  = ST_ERROR;
                        to_cnt_d = '0;
                    end else begin
                        state_d  = ST_FETCH;
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
`else
                    state_d = ST_FETCH;
`endif
                end
            end

            // Registered FIFO read port: the popped word is on fifo_rdata now.
            ST_CAPTURE: begin
                data_d  = fifo_rdata;
                state_d = ST_SEND;
            end

            ST_SEND: begin
                if (wr_ready) begin
                    if (word_cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d     = addr_q + ADDR_W'(1);
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        state_d    = ST_FETCH;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end

            // burst_start arriving here is dropped on purpose.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

`ifdef READER_TIMEOUT_EN
            ST_ERROR: begin
                state_d = ST_IDLE;
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d       = (state_d != ST_IDLE);
        burst_done_d = (state_d == ST_DONE);
        wr_valid_d   = (state_d == ST_SEND);
        wr_last_d    = (state_d == ST_SEND) && (word_cnt_d == LAST_CNT);
`ifdef READER_TIMEOUT_EN
        burst_error_d = (state_d == ST_ERROR);
`endif
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            word_cnt_q   <= '0;
            busy_q       <= 1'b0;
            burst_done_q <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_last_q    <= 1'b0;
`ifdef READER_TIMEOUT_EN
            to_cnt_q      <= '0;
            burst_error_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            word_cnt_q   <= word_cnt_d;
            busy_q       <= busy_d;
            burst_done_q <= burst_done_d;
            wr_valid_q   <= wr_valid_d;
            wr_last_q    <= wr_last_d;
`ifdef READER_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
            burst_error_q <= burst_error_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign burst_done = burst_done_q;
    assign wr_valid   = wr_valid_q;
    assign wr_last    = wr_last_q;
    // addr_q / data_q only change on acceptance / capture, so they are
    // stable for the whole time a word is being offered.
    assign wr_addr    = addr_q;
    assign wr_data    = data_q;

`ifdef READER_TIMEOUT_EN
    assign burst_error = burst_error_q;
`else
    assign burst_error = 1'b0;
`endif

endmodule : fifo_burst_reader

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
// Directed bench for fifo_burst_reader with BURST_LEN=4, ADDR_W=22. A small
// FIFO model with a registered read port feeds the DUT. Burst scenarios come
// from a table of hand-computed expected addresses and data; reset and
// timeout corner cases are written out as explicit sequences.
// With READER_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=8.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

    localparam int AW = 22;

    logic          clk = 1'b0;
    logic          rst;
    logic          burst_start;
    logic [AW-1:0] start_addr;
    logic          busy;
    logic          burst_done;
    logic          fifo_empty;
    logic [31:0]   fifo_rdata;
    logic          fifo_read_enable;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          wr_last;
    logic          burst_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .BURST_LEN(4),
        .ADDR_W(AW)
`ifdef READER_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .burst_start(burst_start),
        .start_addr(start_addr),
        .busy(busy),
        .burst_done(burst_done),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_read_enable(fifo_read_enable),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_last(wr_last),
        .burst_error(burst_error)
    );

    // FIFO model: registered read port, emptied by every reset.
    logic [31:0] mem [0:63];
    logic [5:0]  wr_ptr = 6'd0;
    logic [5:0]  rd_ptr;
    logic        hold_empty = 1'b0;

    assign fifo_empty = hold_empty || (wr_ptr == rd_ptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= 6'd0;
            fifo_rdata <= 32'h0;
        end else if (fifo_read_enable && (wr_ptr != rd_ptr)) begin
            fifo_rdata <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 6'd1;
        end
    end

    wire [59:0] all_outs = {busy, burst_done, fifo_read_enable, wr_valid, wr_last,
                            burst_error, wr_addr, wr_data};

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 6'd1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0]       start_a;
        logic [31:0]         base;
        int                  stall_word;   // -1: never stall
        int                  stall_len;
        int                  push_every;   // 0: preload all words
        bit                  dup_start;
        logic [3:0][AW-1:0]  exp_addr;
        logic [3:0][31:0]    exp_data;
    } vec_t;

    vec_t vecs [5];

    task automatic run_burst(input vec_t v, input int idx);
        int cyc = 0;
        int pops = 0;
        int violations = 0;
        int acc = 0;
        int stalled = 0;
        int done_cnt = 0;
        int done_cyc = -1;
        int last_hs = -1;
        int first_pop = -1;
        int first_valid = -1;
        int pushed = 0;
        bit holding = 1'b0;
        logic [AW+32:0] snap = '0;
        logic [AW-1:0] got_addr [4];
        logic [31:0]   got_data [4];
        logic          got_last [4];
        bit finished = 1'b0;

        if (v.push_every == 0) begin
            for (int i = 0; i < 4; i++) push(v.base + 32'(i));
        end
        @(negedge clk);
        start_addr  = v.start_a;
        burst_start = 1'b1;
        wr_ready    = 1'b1;
        while (!finished && cyc < 400) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 1) burst_start = 1'b0;
            if (v.dup_start && cyc == 6) begin
                burst_start = 1'b1;
                start_addr  = 22'h000777;
            end
            if (v.dup_start && cyc == 7) burst_start = 1'b0;
            if (v.push_every > 0 && pushed < 4 && (cyc % v.push_every) == 5) begin
                push(v.base + 32'(pushed));
                pushed++;
            end
            #1;
            if (fifo_read_enable) begin
                pops++;
                if (first_pop < 0) first_pop = cyc;
                if (fifo_empty) violations++;
            end
            if (burst_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (wr_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (holding) check($sformatf("v%0d_hold", idx), 64'({wr_addr, wr_data, wr_last}), 64'(snap));
                if (acc == v.stall_word && stalled < v.stall_len) begin
                    wr_ready = 1'b0;
                    stalled++;
                    holding  = 1'b1;
                    snap     = {wr_addr, wr_data, wr_last};
                end else begin
                    wr_ready = 1'b1;
                    holding  = 1'b0;
                    if (acc < 4) begin
                        got_addr[acc] = wr_addr;
                        got_data[acc] = wr_data;
                        got_last[acc] = wr_last;
                    end
                    acc++;
                    last_hs = cyc;
                end
            end else begin
                wr_ready = 1'b1;
                holding  = 1'b0;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 4) finished = 1'b1;
            cyc++;
        end

        check($sformatf("v%0d_finished", idx), 64'(finished), 64'd1);
        check($sformatf("v%0d_words", idx), 64'(acc), 64'd4);
        if (acc >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("v%0d_addr%0d", idx, i), 64'(got_addr[i]), 64'(v.exp_addr[i]));
                check($sformatf("v%0d_data%0d", idx, i), 64'(got_data[i]), 64'(v.exp_data[i]));
                check($sformatf("v%0d_last%0d", idx, i), 64'(got_last[i]), 64'(i == 3));
            end
        end
        check($sformatf("v%0d_pops", idx), 64'(pops), 64'd4);
        check($sformatf("v%0d_pop_empty", idx), 64'(violations), 64'd0);
        check($sformatf("v%0d_done_cnt", idx), 64'(done_cnt), 64'd1);
        check($sformatf("v%0d_done_lat", idx), 64'(done_cyc), 64'(last_hs + 1));
        check($sformatf("v%0d_busy_after", idx), 64'(busy), 64'd0);
        if (v.push_every == 0) begin
            check($sformatf("v%0d_first_pop", idx), 64'(first_pop), 64'd1);
            check($sformatf("v%0d_first_valid", idx), 64'(first_valid), 64'd3);
            if (v.stall_len == 0)
                check($sformatf("v%0d_last_hs", idx), 64'(last_hs), 64'd12);
        end
    endtask

    initial begin
        vecs[0] = '{start_a: 22'h000100, base: 32'hA0, stall_word: -1, stall_len: 0,
                    push_every: 0, dup_start: 1'b0,
                    exp_addr: {22'h000103, 22'h000102, 22'h000101, 22'h000100},
                    exp_data: {32'hA3, 32'hA2, 32'hA1, 32'hA0}};
        vecs[1] = '{start_a: 22'h000200, base: 32'hB0, stall_word: 1, stall_len: 5,
                    push_every: 0, dup_start: 1'b0,
                    exp_addr: {22'h000203, 22'h000202, 22'h000201, 22'h000200},
                    exp_data: {32'hB3, 32'hB2, 32'hB1, 32'hB0}};
        vecs[2] = '{start_a: 22'h3FFFFE, base: 32'hC0, stall_word: -1, stall_len: 0,
                    push_every: 0, dup_start: 1'b0,
                    exp_addr: {22'h000001, 22'h000000, 22'h3FFFFF, 22'h3FFFFE},
                    exp_data: {32'hC3, 32'hC2, 32'hC1, 32'hC0}};
        vecs[3] = '{start_a: 22'h000040, base: 32'hE0, stall_word: -1, stall_len: 0,
                    push_every: 10, dup_start: 1'b1,
                    exp_addr: {22'h000043, 22'h000042, 22'h000041, 22'h000040},
                    exp_data: {32'hE3, 32'hE2, 32'hE1, 32'hE0}};
        vecs[4] = '{start_a: 22'h3FFFFF, base: 32'hD0, stall_word: 3, stall_len: 2,
                    push_every: 0, dup_start: 1'b0,
                    exp_addr: {22'h000002, 22'h000001, 22'h000000, 22'h3FFFFF},
                    exp_data: {32'hD3, 32'hD2, 32'hD1, 32'hD0}};

        // Reset with burst_start and fifo_empty toggling.
        rst         = 1'b1;
        burst_start = 1'b0;
        start_addr  = 22'h000123;
        wr_ready    = 1'b0;
        push(32'h55);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            burst_start = ~burst_start;
            hold_empty  = ~hold_empty;
            #1;
            check($sformatf("reset_outs%0d", i), 64'(all_outs), 64'd0);
        end
        burst_start = 1'b0;
        hold_empty  = 1'b0;
        wr_ptr      = 6'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("reset_release_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 5; i++) begin
            run_burst(vecs[i], i);
            repeat (2) @(negedge clk);
        end

        // Reset while a word is being offered.
        begin
            int n = 0;
            int pops = 0;
            int dones = 0;
            int busies = 0;
            for (int i = 0; i < 4; i++) push(32'h90 + 32'(i));
            @(negedge clk);
            start_addr  = 22'h000500;
            burst_start = 1'b1;
            wr_ready    = 1'b0;
            @(negedge clk);
            burst_start = 1'b0;
            while (!wr_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("rstmid_reached_send", 64'(wr_valid), 64'd1);
            rst = 1'b1;
            #1;
            check("rstmid_outs", 64'(all_outs), 64'd0);
            wr_ptr = 6'd0;
            repeat (2) @(negedge clk);
            rst      = 1'b0;
            wr_ready = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                #1;
                if (fifo_read_enable) pops++;
                if (burst_done) dones++;
                if (busy) busies++;
            end
            check("rstmid_no_pop", 64'(pops), 64'd0);
            check("rstmid_no_done", 64'(dones), 64'd0);
            check("rstmid_idle", 64'(busies), 64'd0);
        end

`ifdef READER_TIMEOUT_EN
        // One word then a starved FIFO: timeout after 8 empty FETCH cycles.
        begin
            int err_cyc = -1;
            int err_cnt = 0;
            int dones = 0;
            int hs_cyc = -1;
            logic [31:0] hs_data = 32'h0;
            logic busy_after = 1'b1;
            push(32'hF0);
            @(negedge clk);
            start_addr  = 22'h000010;
            burst_start = 1'b1;
            wr_ready    = 1'b1;
            for (int cyc = 0; cyc < 24; cyc++) begin
                if (cyc > 0) @(negedge clk);
                if (cyc == 1) burst_start = 1'b0;
                #1;
                if (wr_valid && hs_cyc < 0) begin
                    hs_cyc  = cyc;
                    hs_data = wr_data;
                end
                if (burst_error) begin
                    err_cnt++;
                    err_cyc = cyc;
                end
                if (burst_done) dones++;
                if (err_cyc >= 0 && cyc == err_cyc + 1) busy_after = busy;
            end
            check("to_word_cyc", 64'(hs_cyc), 64'd3);
            check("to_word_data", 64'(hs_data), 64'hF0);
            check("to_err_cyc", 64'(err_cyc), 64'd12);
            check("to_err_cnt", 64'(err_cnt), 64'd1);
            check("to_no_done", 64'(dones), 64'd0);
            check("to_busy_after", 64'(busy_after), 64'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fifo_burst_reader
